// File: rtl/forwarding_unit_if.sv
// rtl/forwarding_unit_if.sv - ID instruction input and EX/MEM stage and forward outputs of the forwarding unit
interface forwarding_unit_if;
  logic [15:0] iInstruction;
  logic [5:0]  oInstr_EX;
  logic [5:0]  oInstr_MEM;
  logic        oForwardA_EX;
  logic        oForwardA_MEM;
  logic        oForwardB_EX;
  logic        oForwardB_MEM;

  modport master (
    output iInstruction,
    input  oInstr_EX, oInstr_MEM,
    input  oForwardA_EX, oForwardA_MEM, oForwardB_EX, oForwardB_MEM
  );

  modport slave (
    input  iInstruction,
    output oInstr_EX, oInstr_MEM,
    output oForwardA_EX, oForwardA_MEM, oForwardB_EX, oForwardB_MEM
  );
endinterface

// File: rtl/forwarding_unit.sv
// rtl/forwarding_unit.sv - two-stage opcode pipeline with accumulator A/B forwarding detection
module forwarding_unit (
  input  logic               clk,
  input  logic               reset_n,
  forwarding_unit_if.slave   bus
);

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_ALU   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  logic [5:0] r_instr_ex;
  logic [5:0] r_instr_mem;
  logic [5:0] w_instr_id;

  logic w_id_reads_a;
  logic w_id_reads_b;
  logic w_ex_writes_a;
  logic w_ex_writes_b;
  logic w_mem_writes_a;
  logic w_mem_writes_b;

  function automatic logic f_writes(input logic [5:0] f, input logic reg_sel);
    f_writes = ((f[5:4] == CLS_ALU) || (f[5:4] == CLS_LOAD)) && (f[0] == reg_sel);
  endfunction

  function automatic logic f_reads(input logic [5:0] f, input logic reg_sel);
    f_reads = ((f[5:4] == CLS_ALU) || (f[5:4] == CLS_STORE)) && (f[0] == reg_sel);
  endfunction

  assign w_instr_id = bus.iInstruction[15:10];

  // Async clear makes the stages read as NOP the moment reset asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_ex  <= 6'b000000;
      r_instr_mem <= 6'b000000;
    end else begin
      r_instr_ex  <= w_instr_id;
      r_instr_mem <= r_instr_ex;
    end
  end

  assign w_id_reads_a   = f_reads(w_instr_id, 1'b0);
  assign w_id_reads_b   = f_reads(w_instr_id, 1'b1);
  assign w_ex_writes_a  = f_writes(r_instr_ex, 1'b0);
  assign w_ex_writes_b  = f_writes(r_instr_ex, 1'b1);
  assign w_mem_writes_a = f_writes(r_instr_mem, 1'b0);
  assign w_mem_writes_b = f_writes(r_instr_mem, 1'b1);

  // The EX copy is younger, so it shadows any MEM writer of the same register.
  assign bus.oForwardA_EX  = w_id_reads_a & w_ex_writes_a;
  assign bus.oForwardA_MEM = w_id_reads_a & w_mem_writes_a & ~w_ex_writes_a;
  assign bus.oForwardB_EX  = w_id_reads_b & w_ex_writes_b;
  assign bus.oForwardB_MEM = w_id_reads_b & w_mem_writes_b & ~w_ex_writes_b;

  assign bus.oInstr_EX  = r_instr_ex;
  assign bus.oInstr_MEM = r_instr_mem;

endmodule

// File: tb/tb_forwarding_unit.sv
// tb/tb_forwarding_unit.sv - randomized and directed self-checking bench for forwarding_unit
module tb_forwarding_unit;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [5:0] hist[$];
  logic [5:0] cur_id;

  forwarding_unit_if bus ();

  forwarding_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_writes(input logic [5:0] f, input int x);
    int cls = int'(f) / 16;
    return (cls == 1 || cls == 2) && (int'(f) % 2 == x);
  endfunction

  function automatic bit m_reads(input logic [5:0] f, input int x);
    int cls = int'(f) / 16;
    return (cls == 1 || cls == 3) && (int'(f) % 2 == x);
  endfunction

  // Expected {EX, MEM, fwdA_EX, fwdA_MEM, fwdB_EX, fwdB_MEM}, from the history of accepted ID fields.
  function automatic logic [15:0] model();
    logic [5:0] ex  = (hist.size() > 0) ? hist[0] : 6'd0;
    logic [5:0] mem = (hist.size() > 1) ? hist[1] : 6'd0;
    logic [3:0] fw;
    for (int x = 0; x < 2; x++) begin
      fw[3 - 2*x] = m_reads(cur_id, x) && m_writes(ex, x);
      fw[2 - 2*x] = m_reads(cur_id, x) && m_writes(mem, x) && !m_writes(ex, x);
    end
    return {ex, mem, fw};
  endfunction

  function automatic logic [15:0] observed();
    return {bus.oInstr_EX, bus.oInstr_MEM, bus.oForwardA_EX, bus.oForwardA_MEM,
            bus.oForwardB_EX, bus.oForwardB_MEM};
  endfunction

  task automatic drive(input logic [5:0] f, output logic [15:0] obs, output logic [15:0] exp);
    @(negedge clk);
    cur_id = f;
    bus.iInstruction = {f, 10'($urandom)};
    #1;
    obs = observed();
    exp = model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      hist.push_front(cur_id);
      if (hist.size() > 2) void'(hist.pop_back());
    end
  endtask

  task automatic test_reset();
    logic [15:0] obs, exp;
    reset_n = 1'b0;
    hist.delete();
    drive(6'b010000, obs, exp);
    tick();
    drive(6'b010000, obs, exp);
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL reset_hold: got %h want %h", obs, 16'h0000);
    end
    reset_n = 1'b1;
    tick();
    drive(6'b000000, obs, exp);
    total++;
    if (obs !== exp || obs !== {6'b010000, 6'b000000, 4'b0000}) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", obs, {6'b010000, 6'b000000, 4'b0000});
    end
    tick();
  endtask

  task automatic test_load_alu();
    logic [15:0] obs, exp;
    drive(6'b100000, obs, exp); tick();
    drive(6'b010000, obs, exp);
    total++;
    if (obs !== exp || obs[3:0] !== 4'b1000) begin
      bad++;
      $display("FAIL load_alu_a: got %h want %h", obs, exp);
    end
    tick();
  endtask

  task automatic test_load_nop_store();
    logic [15:0] obs, exp;
    drive(6'b100001, obs, exp); tick();
    drive(6'b000000, obs, exp); tick();
    drive(6'b110001, obs, exp);
    total++;
    if (obs !== exp || obs[3:0] !== 4'b0001) begin
      bad++;
      $display("FAIL load_nop_store_b: got %h want %h", obs, exp);
    end
    tick();
  endtask

  task automatic test_ex_priority();
    logic [15:0] obs, exp;
    drive(6'b100000, obs, exp); tick();
    drive(6'b010000, obs, exp); tick();
    drive(6'b110000, obs, exp);
    total++;
    if (obs !== exp || obs[3:0] !== 4'b1000) begin
      bad++;
      $display("FAIL ex_priority_a: got %h want %h", obs, exp);
    end
    tick();
  endtask

  task automatic test_no_read();
    logic [15:0] obs, exp;
    drive(6'b100001, obs, exp); tick();
    drive(6'b100000, obs, exp); tick();
    drive(6'b110001, obs, exp);
    total++;
    if (obs !== exp || obs[3:0] !== 4'b0001) begin
      bad++;
      $display("FAIL store_b_mem_only: got %h want %h", obs, exp);
    end
    tick();
    drive(6'b110001, obs, exp);
    total++;
    if (obs !== exp || obs[3:0] !== 4'b0000) begin
      bad++;
      $display("FAIL store_b_vs_load_a: got %h want %h", obs, exp);
    end
    tick();
    drive(6'b010001, obs, exp); tick();
    drive(6'b000000, obs, exp);
    total++;
    if (obs !== exp || obs[3:0] !== 4'b0000) begin
      bad++;
      $display("FAIL nop_in_id: got %h want %h", obs, exp);
    end
    tick();
    drive(6'b101111, obs, exp);
    total++;
    if (obs !== exp || obs[3:0] !== 4'b0000) begin
      bad++;
      $display("FAIL load_in_id: got %h want %h", obs, exp);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [15:0] obs, exp;
    drive(6'b100000, obs, exp); tick();
    drive(6'b010000, obs, exp);
    total++;
    if (obs !== exp || obs[3:0] !== 4'b1000) begin
      bad++;
      $display("FAIL pre_async_reset: got %h want %h", obs, exp);
    end
    #1 reset_n = 1'b0;
    hist.delete();
    #1;
    obs = observed();
    total++;
    if (obs !== 16'h0000) begin
      bad++;
      $display("FAIL async_reset_immediate: got %h want %h", obs, 16'h0000);
    end
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    drive(6'b110000, obs, exp);
    total++;
    if (obs !== exp || obs[15:4] !== {6'b010000, 6'b000000}) begin
      bad++;
      $display("FAIL after_async_reset: got %h want %h", obs, exp);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] obs, exp;
    for (int i = 0; i < 400; i++) begin
      drive(6'($urandom), obs, exp);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL random[%0d] id=%b: got %h want %h", i, cur_id, obs, exp);
      end
      if (obs[3] && obs[2] || obs[1] && obs[0]) begin
        bad++;
        $display("FAIL random_prio[%0d]: got %b want no EX+MEM overlap", i, obs[3:0]);
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    cur_id = 6'd0;
    bus.iInstruction = 16'h0000;
    test_reset();
    test_load_alu();
    test_load_nop_store();
    test_ex_priority();
    test_no_read();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
